// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants, derived totals and decode helper shared by the scan generator and overlays.
package vga_timing_pkg;
    localparam int DEF_H_VIS = 640;
    localparam int DEF_H_FP  = 16;
    localparam int DEF_H_SW  = 96;
    localparam int DEF_H_BP  = 48;
    localparam int DEF_V_VIS = 480;
    localparam int DEF_V_FP  = 10;
    localparam int DEF_V_SW  = 2;
    localparam int DEF_V_BP  = 33;
    localparam int H_TOTAL      = DEF_H_VIS + DEF_H_FP + DEF_H_SW + DEF_H_BP;
    localparam int V_TOTAL      = DEF_V_VIS + DEF_V_FP + DEF_V_SW + DEF_V_BP;
    localparam int H_SYNC_START = DEF_H_VIS + DEF_H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SW - 1;
    localparam int V_SYNC_START = DEF_V_VIS + DEF_V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SW - 1;
    typedef logic [9:0] coord_t;
    function automatic logic in_span(input coord_t v, input coord_t lo, input coord_t hi);
        return v >= lo && v <= hi;
    endfunction
endpackage

// File: rtl/vga_counter.sv
// vga_counter: pixel/line counter pair advancing on the pixel enable, flags the frame wrap.
module vga_counter
    import vga_timing_pkg::*;
#(
    parameter int H_TOT = H_TOTAL,
    parameter int V_TOT = V_TOTAL
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       wrap
);
    localparam coord_t X_LAST = coord_t'(H_TOT - 1);
    localparam coord_t Y_LAST = coord_t'(V_TOT - 1);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (tick) begin
            x <= (x == X_LAST) ? '0 : x + 10'd1;
            if (x == X_LAST)
                y <= (y == Y_LAST) ? '0 : y + 10'd1;
        end
    end
    assign wrap = tick && x == X_LAST && y == Y_LAST;
endmodule

// File: rtl/vga_scan_gen.sv
// vga_scan_gen: VGA raster timing with registered sync/blank/colour, one pixel behind x,y.
module vga_scan_gen
    import vga_timing_pkg::*;
#(
    parameter int         H_VIS  = DEF_H_VIS,
    parameter int         H_FP   = DEF_H_FP,
    parameter int         H_SW   = DEF_H_SW,
    parameter int         H_BP   = DEF_H_BP,
    parameter int         V_VIS  = DEF_V_VIS,
    parameter int         V_FP   = DEF_V_FP,
    parameter int         V_SW   = DEF_V_SW,
    parameter int         V_BP   = DEF_V_BP,
    parameter logic [2:0] BG_RGB = 3'b000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] x,
    output logic [9:0] y,
    input  logic [2:0] stbd_rgb,
    input  logic       stbd_valid,
    output logic       pixel_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [2:0] rgb,
    output logic       frame_tick
);
    localparam coord_t X_VIS = coord_t'(H_VIS);
    localparam coord_t Y_VIS = coord_t'(V_VIS);
    localparam coord_t HS_LO = coord_t'(H_VIS + H_FP);
    localparam coord_t HS_HI = coord_t'(H_VIS + H_FP + H_SW - 1);
    localparam coord_t VS_LO = coord_t'(V_VIS + V_FP);
    localparam coord_t VS_HI = coord_t'(V_VIS + V_FP + V_SW - 1);
    logic div;
    logic visible;
    logic hsync_n;
    logic vsync_n;
    always_ff @(posedge clk) begin
        div <= rst_n ? ~div : 1'b0;
    end
    assign pixel_tick = div;
    vga_counter #(
        .H_TOT(H_VIS + H_FP + H_SW + H_BP),
        .V_TOT(V_VIS + V_FP + V_SW + V_BP)
    ) u_counter (
        .clk(clk),
        .rst_n(rst_n),
        .tick(div),
        .x(x),
        .y(y),
        .wrap(frame_tick)
    );
    always_comb begin
        visible = x < X_VIS && y < Y_VIS;
        hsync_n = !in_span(x, HS_LO, HS_HI);
        vsync_n = !in_span(y, VS_LO, VS_HI);
    end
    // All outputs load on the same tick so they stay aligned one pixel behind x,y.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            video_on <= 1'b0;
            rgb      <= 3'b000;
        end else if (div) begin
            hsync    <= hsync_n;
            vsync    <= vsync_n;
            video_on <= visible;
            rgb      <= !visible ? 3'b000 : (stbd_valid ? stbd_rgb : BG_RGB);
        end
    end
endmodule

// File: doc/vga_scan_gen.md
VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

Interface
REQ-001 Parameter H_VIS, 640, visible pixels per line.
REQ-002 Parameter H_FP, 16, horizontal front porch in pixels.
REQ-003 Parameter H_SW, 96, hsync pulse width in pixels.
REQ-004 Parameter H_BP, 48, horizontal back porch in pixels; line total is H_VIS+H_FP+H_SW+H_BP = 800.
REQ-005 Parameter V_VIS, 480, visible lines per frame.
REQ-006 Parameter V_FP, 10, vertical front porch in lines.
REQ-007 Parameter V_SW, 2, vsync pulse width in lines.
REQ-008 Parameter V_BP, 33, vertical back porch in lines; frame total is 525 lines.
REQ-009 Parameter BG_RGB, 3'b000, colour driven for visible pixels not claimed by an overlay.
REQ-010 Port clk, input, 1, system clock (50 MHz); the single clock, all logic on its rising edge.
REQ-011 Port rst_n, input, 1, synchronous active-low reset.
REQ-012 Port x, output, 10, current horizontal pixel counter (0..799).
REQ-013 Port y, output, 10, current vertical line counter (0..524).
REQ-014 Port stbd_rgb, input, 3, overlay colour returned combinationally by the overlay renderer for the current x,y.
REQ-015 Port stbd_valid, input, 1, overlay claims the current x,y pixel.
REQ-016 Port pixel_tick, output, 1, one-clk pulse every second clk; the 25 MHz pixel enable.
REQ-017 Port hsync, output, 1, horizontal sync, active low.
REQ-018 Port vsync, output, 1, vertical sync, active low.
REQ-019 Port video_on, output, 1, high while the output pixel is in the visible area.
REQ-020 Port rgb, output, 3, final pixel colour to the DAC pins.
REQ-021 Port frame_tick, output, 1, one-clk pulse at the start of each frame.

Function
REQ-022 pixel_tick SHALL toggle from a 1-bit divider: 0 in the first clk after reset release, then 1, 0, 1, and so on.
REQ-023 x SHALL increment on each clk where pixel_tick=1; at 799 it SHALL wrap to 0 and advance y by one.
REQ-024 y SHALL wrap from 524 to 0 on the same tick that x wraps from 799.
REQ-025 Counters SHALL hold when pixel_tick=0.
REQ-026 Decode SHALL be computed from the counters before the tick:
- visible = x<640 && y<480
- hsync_n = !(656<=x<=751)
- vsync_n = !(490<=y<=491)
REQ-027 On each pixel_tick the block SHALL register:
- video_on <= visible
- hsync <= hsync_n
- vsync <= vsync_n
- rgb <= !visible ? 3'b000 : (stbd_valid ? stbd_rgb : BG_RGB)
REQ-028 The result of REQ-027 SHALL be a fixed one-pixel latency from x,y to the output group; the output group SHALL stay mutually aligned.
REQ-029 rgb SHALL be 3'b000 whenever the registered video_on is 0, regardless of stbd_valid.
REQ-030 frame_tick SHALL pulse for one clk on the tick where x=799 and y=524 (the wrap to 0,0), and at no other time.
REQ-031 stbd_rgb and stbd_valid SHALL be sampled only on pixel_tick clks; changes between ticks SHALL have no effect.

Reset
REQ-032 While rst_n=0 at a clk edge, the block SHALL force x=0, y=0, divider=0, hsync=1, vsync=1, video_on=0, rgb=3'b000, frame_tick=0 and pixel_tick=0.
REQ-033 Reset asserted mid-line or mid-frame SHALL restart timing at 0,0 on the first clk after release; no partial sync pulse SHALL be extended.

Structure
REQ-034 Timing parameters and derived totals (H_TOTAL=800, V_TOTAL=525, sync start/end) SHALL live in a shared package vga_timing_pkg, reused by overlay blocks.
REQ-035 The h/v counter pair SHALL be one sub-module vga_counter (inputs clk, rst_n, tick; outputs x, y, wrap); the sync decode and pixel mux SHALL stay in vga_scan_gen.

Verification
REQ-036 Reset, then run 2 lines: pixel_tick period = 2 clk; x reaches 799 then 0 with y 0->1; hsync is low for exactly 96 ticks, with the low edge registered after x=656.
REQ-037 Full frame: vsync is low for exactly 2 lines (y 490,491, delayed one tick); frame_tick pulses exactly once per 800*525*2 = 840000 clk.
REQ-038 With stbd_valid=1 and stbd_rgb=3'b110 only at x=600,y=30, the bench SHALL check:
- rgb=3'b110 on the tick after x=600,y=30
- rgb=BG_RGB at the neighbouring pixels
REQ-039 With stbd_valid=1 and stbd_rgb=3'b011 held constant: rgb=3'b000 and video_on=0 for every x>=640 and every y>=480.
REQ-040 With rst_n driven low for 3 clk at x=300,y=200: the next tick after release shows x=0, y=0, hsync=1, vsync=1, rgb=0.
